fifo_reader: RTL and testbench
==============================

// Module: fifo_reader
// PURPOSE
// - Drains the FIFO: drives pop, captures FIFO data_out after the RAM read latency, and presents words downstream on a valid/ready stream.
// - Sits between the FIFO read side (pop/empty/data_out) and any consumer.
// - Full throughput (1 word/clk) when the FIFO is non-empty and m_ready is held high.
// - No word is lost or duplicated under backpressure.
// PARAMETERS
// - DATA_W     16  width of data_t words (matches fifo_pkg data_t)
// - RD_LAT     1   clocks from pop high at an edge to the word valid on fifo_data (1..3)
// - BUF_DEPTH  2   holding-buffer entries; must be >= RD_LAT+1
// - CNT_W      16  width of word_cnt (only with FIFO_READER_STATS_EN)
// PORTS
// - clk         in   1       system clock, rising edge
// - rst         in   1       asynchronous reset, active-low
// - enable      in   1       1 = fetch from the FIFO; 0 = stop issuing pops and drain
// - fifo_empty  in   1       FIFO empty flag
// - fifo_data   in   DATA_W  FIFO read data
// - fifo_pop    out  1       pop strobe to the FIFO, one word per high cycle
// - m_valid     out  1       downstream word valid
// - m_data      out  DATA_W  downstream word
// - m_ready     in   1       downstream accepts when m_valid && m_ready
// - busy        out  1       1 while the FSM is not IDLE
// - word_cnt    out  CNT_W   words delivered downstream (FIFO_READER_STATS_EN only)
// BEHAVIOUR
// - Reset (rst=0, async): all of the following are cleared.
//   - Outputs: fifo_pop=0, m_valid=0, m_data=0, busy=0, word_cnt=0.
//   - State: buffer emptied, in-flight pipe cleared, state=IDLE.
//   - Reset mid-transfer discards buffered and in-flight words.
// - Internal bookkeeping:
//   - occ = buffered words (0..BUF_DEPTH).
//   - infl = pops issued whose data has not yet arrived; tracked by an RD_LAT-deep shift of fifo_pop.
// - Pop rule (combinational):
//   - fifo_pop = (state==RUN) && !fifo_empty && (occ + infl - deq < BUF_DEPTH),
//   - where deq = m_valid && m_ready.
// - Capture: when the delayed pop bit exits the shift, fifo_data is written into the buffer tail that cycle.
// - Buffer: in-order FIFO of BUF_DEPTH entries.
//   - m_data = head; m_valid = (occ != 0).
//   - m_data stays stable while m_valid && !m_ready.
// - Simultaneous capture and deq: occ unchanged; the head advances; the new word goes to the tail.
// - Write-through: with occ=0, the word is registered first; m_valid rises the cycle after capture.
//   - Pop-to-m_valid latency = RD_LAT+1 clocks.
// - FSM (busy = state!=IDLE):
//   - IDLE -> RUN when enable=1.
//   - RUN -> DRAIN when enable=0.
//   - DRAIN -> IDLE when infl==0 && occ==0.
//   - DRAIN -> RUN when enable=1.
//   - IDLE and DRAIN never assert fifo_pop.
// - fifo_empty=1: no pop. fifo_empty toggling is honoured cycle by cycle; no pop is ever issued on empty.
// - Buffer full: no pop until a deq occurs. With m_ready stuck low, exactly BUF_DEPTH words leave the FIFO.
// CONFIGURATION
// - FIFO_READER_STATS_EN defined:
//   - word_cnt increments by 1 on each deq and wraps at 2^CNT_W-1 -> 0.
//   - Cleared only by reset.
// - FIFO_READER_STATS_EN undefined: word_cnt port and counter are absent; no other behaviour changes.
// TESTING
// - Reset mid-stream (rst=0 while occ=2) -> m_valid=0, fifo_pop=0, busy=0 immediately; no stale word after release.
// - FIFO preloaded 0x0001..0x0008, enable=1, m_ready=1 -> 8 pops on consecutive clocks; m_data 0x0001..0x0008 on 8 consecutive cycles.
// - Same preload, m_ready=0 for 10 cycles, then 1:
//   - exactly 2 pops during the stall; m_data holds 0x0001;
//   - then all 8 words are delivered in order, none duplicated.
// - enable 1->0 after 3 pops:
//   - no further pops; the 3 words are delivered;
//   - busy falls after the last deq; 5 words remain in the FIFO.
// - fifo_empty pulsing 1/0 each cycle with m_ready random -> fifo_pop never high while fifo_empty=1; output order matches input.
// - STATS_EN, CNT_W=4, 18 words delivered -> word_cnt=2 (wrapped).

Source files
------------

// File: rtl/fifo_reader.sv
// Drains a FIFO with a fixed RAM read latency into a valid/ready stream via a small holding buffer.
// Optional word counter on the output side is enabled by defining FIFO_READER_STATS_EN.
module fifo_reader #(
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_W-1:0]  word_cnt
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int SW = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]     occ_q;
  logic              capture;
  logic              deq;
  logic [SW-1:0]     infl;
  logic [SW-1:0]     pending;

  function automatic logic [SW-1:0] count_ones(input logic [RD_LAT-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) n = n + SW'(v[i]);
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign capture = pipe_q[RD_LAT-1];
  assign m_valid = (occ_q != '0);
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign deq     = m_valid && m_ready;
  assign infl    = count_ones(pipe_q);
  assign pending = SW'(occ_q) + infl;
  assign busy    = (state_q != IDLE);

  // A slot freed by this cycle's deq may be reused by this cycle's pop.
  assign fifo_pop = (state_q == RUN) && !fifo_empty &&
                    (pending < (SW'(BUF_DEPTH) + SW'(deq)));

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = fifo_pop;
    for (int i = RD_LAT - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                               state_d = RUN;
        else if ((infl == '0) && (occ_q == '0))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pipe_q   <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      occ_q   <= occ_q + OW'(capture) - OW'(deq);
      if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq)     rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Buffer storage carries no reset; m_data is masked while nothing is buffered.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= fifo_data;
  end

`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt_q <= '0;
    else if (deq) cnt_q <= cnt_q + 1'b1;
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed bench for fifo_reader against a queue-based transaction model.
module tb_fifo_reader;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 2;
`ifdef FIFO_READER_STATS_EN
  localparam int CNT_W     = 4;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic              busy;
`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0]  word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)
`ifdef FIFO_READER_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy)
`ifdef FIFO_READER_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  // Source FIFO, outstanding-word scoreboard, delivery logs
  logic [DATA_W-1:0] src_q[$];
  int                src_cnt = 0;
  logic              empty_force = 1'b0;
  logic [DATA_W-1:0] sb_d[$];
  int                sb_t[$];
  logic [DATA_W-1:0] dlog[$];
  int                pcyc[$];
  int                qcyc[$];
  logic [DATA_W-1:0] dl[RD_LAT];
  int                st = 0;
  int                cyc = 0;
  int                pops = 0;
  int                deq_total = 0;

  assign fifo_empty = (src_cnt == 0) || empty_force;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare at negedge, model advance just after posedge
  initial begin
    logic              ev, mdeq, ep, apop, adeq, en, was_empty, rst_s;
    logic [DATA_W-1:0] w;
    for (int i = 0; i < RD_LAT; i++) dl[i] = 16'hA5A5;
    fifo_data = dl[RD_LAT-1];
    forever begin
      @(negedge clk);
      rst_s = rst;
      mdeq = 1'b0; apop = 1'b0; en = 1'b0; was_empty = 1'b1;
      if (!rst) begin
        sb_d.delete(); sb_t.delete();
        st = 0; deq_total = 0;
      end else begin
        ev   = (sb_d.size() > 0) && (sb_t[0] <= cyc);
        mdeq = ev && m_ready;
        ep   = (st == 1) && !fifo_empty && ((sb_d.size() - int'(mdeq)) < BUF_DEPTH);
        chk("fifo_pop", 32'(fifo_pop), 32'(ep));
        chk("m_valid", 32'(m_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(st != 0));
        if (ev) chk("m_data", 32'(m_data), 32'(sb_d[0]));
`ifdef FIFO_READER_STATS_EN
        chk("word_cnt", 32'(word_cnt), 32'(deq_total % (1 << CNT_W)));
`endif
        apop = fifo_pop;
        adeq = m_valid && m_ready;
        if (adeq) begin
          dlog.push_back(m_data);
          qcyc.push_back(cyc);
        end
        en = enable;
        was_empty = (sb_d.size() == 0);
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
        if (mdeq) begin
          void'(sb_d.pop_front());
          void'(sb_t.pop_front());
          deq_total++;
        end
        for (int i = RD_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
        w = 16'(($urandom()));
        if (apop) begin
          if (src_q.size() > 0) w = src_q.pop_front();
          sb_d.push_back(w);
          sb_t.push_back(cyc + RD_LAT + 1);
          pcyc.push_back(cyc);
          pops++;
        end
        dl[0] = w;
        fifo_data = dl[RD_LAT-1];
        case (st)
          0: if (en) st = 1;
          1: if (!en) st = 2;
          default: if (en) st = 1; else if (was_empty) st = 0;
        endcase
        src_cnt = src_q.size();
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_seq(input int first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(16'(first + i));
    src_cnt = src_q.size();
  endtask

  task automatic clear_logs();
    dlog.delete(); pcyc.delete(); qcyc.delete();
    pops = 0;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int k = 0;
    while ((dlog.size() < n) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("deliv_count", 32'(dlog.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    step(1);
  endtask

  task automatic chk_seq(input string nm, input int first, input int n);
    for (int i = 0; i < n; i++)
      if (i < dlog.size()) chk(nm, 32'(dlog[i]), 32'(first + i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] v;

    step(2);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst = 1'b1;
    step(2);

    // Full throughput
    clear_logs();
    load_seq(1, 8);
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_deliv(8, 40);
    chk("A_pops", 32'(pops), 32'd8);
    if (pcyc.size() == 8) chk("A_pop_span", 32'(pcyc[7] - pcyc[0]), 32'd7);
    if (qcyc.size() == 8) chk("A_deq_span", 32'(qcyc[7] - qcyc[0]), 32'd7);
    if (pcyc.size() > 0 && qcyc.size() > 0)
      chk("A_latency", 32'(qcyc[0] - pcyc[0]), 32'(RD_LAT + 1));
    chk_seq("A_data", 1, 8);
    enable = 1'b0;
    wait_idle(20);

    // Backpressure stall
    clear_logs();
    load_seq(1, 8);
    m_ready = 1'b0;
    enable  = 1'b1;
    step(10);
    chk("B_stall_pops", 32'(pops), 32'd2);
    chk("B_stall_hold", 32'(m_data), 32'h0001);
    m_ready = 1'b1;
    wait_deliv(8, 60);
    step(5);
    chk("B_no_dup", 32'(dlog.size()), 32'd8);
    chk_seq("B_data", 1, 8);
    enable = 1'b0;
    wait_idle(20);

    // Enable drop after three pops
    clear_logs();
    load_seq(1, 8);
    m_ready = 1'b1;
    enable  = 1'b1;
    step(3);
    enable = 1'b0;
    wait_idle(30);
    chk("C_pops", 32'(pops), 32'd3);
    chk("C_left", 32'(src_cnt), 32'd5);
    chk("C_deliv", 32'(dlog.size()), 32'd3);
    chk_seq("C_data", 1, 3);
    src_q.delete();
    src_cnt = 0;
    step(1);

    // Random data, pulsing empty, random ready and occasional enable drops
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom());
      exp_q.push_back(v);
      src_q.push_back(v);
    end
    src_cnt = src_q.size();
    enable = 1'b1;
    for (int i = 0; i < 400 && dlog.size() < 40; i++) begin
      empty_force = ~empty_force;
      m_ready = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      step(1);
    end
    empty_force = 1'b0;
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_deliv(40, 200);
    for (int i = 0; i < 40; i++)
      if (i < dlog.size()) chk("D_order", 32'(dlog[i]), 32'(exp_q[i]));
    enable = 1'b0;
    wait_idle(20);

    // Reset while the buffer is full
    clear_logs();
    load_seq(1, 8);
    m_ready = 1'b0;
    enable  = 1'b1;
    step(6);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("E_rst_m_valid", 32'(m_valid), 32'd0);
    chk("E_rst_fifo_pop", 32'(fifo_pop), 32'd0);
    chk("E_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    dlog.delete();
    m_ready = 1'b1;
    wait_deliv(6, 40);
    if (dlog.size() > 0) chk("E_no_stale", 32'(dlog[0]), 32'h0003);
    chk_seq("E_data", 3, 6);

    // Twelve more words: 18 deliveries since reset
    load_seq(9, 12);
    wait_deliv(18, 80);
    chk_seq("F_data", 3, 18);
    enable = 1'b0;
    wait_idle(20);
`ifdef FIFO_READER_STATS_EN
    chk("F_word_cnt_wrap", 32'(word_cnt), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
